dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 148 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory with sized, extended loads and lane-masked stores.
// Optional power-up clear sequence enabled by DMEM_CLEAR_ON_RESET_EN.
module dmem_ctrl #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [31:0]       wdata_i,
    input  logic              memwrite_i,
    input  logic              memread_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned AW_FULL = IDX_W + 2;

    logic [31:0] mem [DEPTH];

    logic             clr_we_c;
    logic [IDX_W-1:0] clr_idx_c;

`ifdef DMEM_CLEAR_ON_RESET_EN
    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Sweep one word per cycle, then settle in IDLE until the next reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we_c  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clr_we_c  = 1'b1;
                clr_cnt_d = IDX_W'(clr_cnt_q + 1'b1);
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: ;
            default: state_d = ST_IDLE;
        endcase
    end

    assign clr_idx_c = clr_cnt_q;
    assign busy_o    = (state_q == ST_INIT);
`else
    assign clr_we_c  = 1'b0;
    assign clr_idx_c = '0;
    assign busy_o    = 1'b0;
`endif

    logic [IDX_W-1:0] idx_c;
    logic [1:0]       lane_c;
    logic             oob_c, bad_c, req_c, wr_c, rd_c;
    logic [3:0]       be_c;
    logic [31:0]      wd_c, rword_c, ext_c;
    logic [7:0]       rbyte_c;
    logic [15:0]      rhalf_c;

    assign idx_c  = address_i[IDX_W+1:2];
    assign lane_c = address_i[1:0];
    assign oob_c  = |(address_i >> AW_FULL);

    // Request decode: legality, lane enables and replicated store data
    always_comb begin
        be_c  = 4'b0000;
        wd_c  = wdata_i;
        bad_c = oob_c;
        unique case (size_i)
            2'b00: begin
                be_c = 4'b0001 << lane_c;
                wd_c = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_c  = lane_c[1] ? 4'b1100 : 4'b0011;
                wd_c  = {2{wdata_i[15:0]}};
                bad_c = oob_c | lane_c[0];
            end
            2'b10: begin
                be_c  = 4'b1111;
                bad_c = oob_c | (lane_c != 2'b00);
            end
            default: bad_c = 1'b1;
        endcase
    end

    assign req_c = ~busy_o & (memwrite_i | memread_i);
    assign wr_c  = req_c & memwrite_i & ~bad_c;
    assign rd_c  = req_c & ~memwrite_i & memread_i;

    always_ff @(posedge clk_i) begin
        if (clr_we_c && !rst_i) begin
            mem[clr_idx_c] <= '0;
        end else if (wr_c && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= wd_c[8*b +: 8];
                end
            end
        end
    end

    // Right-align the selected lane(s) and extend to 32 bits
    always_comb begin
        rword_c = mem[idx_c];
        rbyte_c = rword_c[{lane_c, 3'b000} +: 8];
        rhalf_c = rword_c[{lane_c[1], 4'b0000} +: 16];
        unique case (size_i)
            2'b00:   ext_c = unsigned_i ? {24'b0, rbyte_c} : {{24{rbyte_c[7]}}, rbyte_c};
            2'b01:   ext_c = unsigned_i ? {16'b0, rhalf_c} : {{16{rhalf_c[15]}}, rhalf_c};
            default: ext_c = rword_c;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= rd_c;
            err_o    <= req_c & bad_c;
            if (rd_c) begin
                rdata_o <= bad_c ? 32'h0 : ext_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (DEPTH=16); INIT checks run when DMEM_CLEAR_ON_RESET_EN is defined.
module tb_dmem_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] address_i;
    logic [31:0] wdata_i;
    logic        memwrite_i;
    logic        memread_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        err_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    dmem_ctrl #(.DEPTH(16), .ADDR_W(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .address_i  (address_i),
        .wdata_i    (wdata_i),
        .memwrite_i (memwrite_i),
        .memread_i  (memread_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for one rising edge; returns at the following falling edge
    task automatic req(input logic we, input logic re, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
        memwrite_i = we;
        memread_i  = re;
        size_i     = sz;
        unsigned_i = uns;
        address_i  = addr;
        wdata_i    = wd;
        @(negedge clk_i);
        memwrite_i = 1'b0;
        memread_i  = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] d, input logic v, input logic e);
        check({tag, ".rdata"}, rdata_o, d);
        check({tag, ".rvalid"}, 32'(rvalid_o), 32'(v));
        check({tag, ".err"}, 32'(err_o), 32'(e));
    endtask

    // Count busy cycles after reset release while an illegal load is held pending
    task automatic count_busy(output int n, output int spurious);
        n = 0;
        spurious = 0;
        memread_i = 1'b1;
        size_i    = 2'b11;
        for (int i = 0; i < 40; i++) begin
            if (rvalid_o || err_o) spurious++;
            if (!busy_o) break;
            n++;
            @(negedge clk_i);
        end
        memread_i = 1'b0;
    endtask

    int nb, sp;

    initial begin
        rst_i = 1'b1; memwrite_i = 1'b0; memread_i = 1'b0; size_i = 2'b10;
        unsigned_i = 1'b0; address_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk_i);
        chk_resp("reset", 32'h0, 1'b0, 1'b0);
        rst_i = 1'b0;

`ifdef DMEM_CLEAR_ON_RESET_EN
        count_busy(nb, sp);
        check("init.busy_cycles", 32'(nb), 32'd16);
        check("init.no_response", 32'(sp), 32'd0);

        // Reset again at INIT cycle 5; the clear must restart and last a full 16 cycles
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("init5.busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        count_busy(nb, sp);
        check("reinit.busy_cycles", 32'(nb), 32'd16);
        check("reinit.no_response", 32'(sp), 32'd0);
`else
        check("nomacro.busy", 32'(busy_o), 32'd0);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
`endif
        check("idle.busy", 32'(busy_o), 32'd0);

        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h3C, 32'h0);
        chk_resp("ld3c", 32'h0, 1'b1, 1'b0);
        @(negedge clk_i);
        check("ld3c.pulse_end", 32'(rvalid_o), 32'd0);

        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h11223344);
        chk_resp("st08", 32'h0, 1'b0, 1'b0);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h09, 32'hFFFFFFAA);
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0);
        chk_resp("ld08", 32'h1122AA44, 1'b1, 1'b0);

        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h80F0FF7F);
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
        check("lb10.s", rdata_o, 32'h0000007F);
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0);
        check("lb13.s", rdata_o, 32'hFFFFFF80);
        req(1'b0, 1'b1, 2'b01, 1'b1, 32'h12, 32'h0);
        check("lh12.u", rdata_o, 32'h000080F0);
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0);
        check("lh12.s", rdata_o, 32'hFFFF80F0);
        req(1'b0, 1'b1, 2'b00, 1'b1, 32'h13, 32'h0);
        check("lb13.u", rdata_o, 32'h00000080);
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0);
        check("lb11.s", rdata_o, 32'hFFFFFFFF);
        req(1'b0, 1'b1, 2'b10, 1'b1, 32'h10, 32'h0);
        check("lw10.u", rdata_o, 32'h80F0FF7F);

        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h55667788);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h05, 32'h0000FFFF);
        chk_resp("sh05.bad", 32'h80F0FF7F, 1'b0, 1'b1);
        @(negedge clk_i);
        check("sh05.err_end", 32'(err_o), 32'd0);
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h0);
        check("ld04.unchanged", rdata_o, 32'h55667788);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h06, 32'h1234BEEF);
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h0);
        check("ld04.half", rdata_o, 32'hBEEF7788);

        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
        chk_resp("ld40.oob", 32'h0, 1'b1, 1'b1);

        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h00, 32'hDEADBEEF);
        chk_resp("wr_rd", 32'h0, 1'b0, 1'b0);
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0);
        chk_resp("ld00", 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clk_i);
        chk_resp("hold", 32'hDEADBEEF, 1'b0, 1'b0);

        req(1'b0, 1'b1, 2'b11, 1'b0, 32'h00, 32'h0);
        chk_resp("ld.size11", 32'h0, 1'b1, 1'b1);
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0);
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0A, 32'h0);
        chk_resp("lw0a.misalign", 32'h0, 1'b1, 1'b1);

        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_resp("midreset", 32'h0, 1'b0, 1'b0);
        rst_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
